// File: rtl/tengig_eth_tx_frame_fifo.sv
// Store-and-forward 10GbE TX frame buffer: a frame reaches the MAC only after its
// last beat is stored, so the MAC never underruns; frames that do not fit are dropped whole.
module tengig_eth_tx_frame_fifo #(
  parameter int FIFO_AWIDTH = 10,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 piETH_CoreClk,
  input  logic                 piETH_CoreReset,
  input  logic [63:0]          siELP_Data_tdata,
  input  logic [7:0]           siELP_Data_tkeep,
  input  logic                 siELP_Data_tlast,
  input  logic                 siELP_Data_tvalid,
  output logic                 siELP_Data_tready,
  output logic [63:0]          soLY2_Data_tdata,
  output logic [7:0]           soLY2_Data_tkeep,
  output logic                 soLY2_Data_tlast,
  output logic                 soLY2_Data_tvalid,
  input  logic                 soLY2_Data_tready,
  output logic [CNT_WIDTH-1:0] poMMIO_FrameCnt,
  output logic [CNT_WIDTH-1:0] poMMIO_DropCnt
);
  localparam int WORD_W = 73;
  localparam int DEPTH  = 1 << FIFO_AWIDTH;

  typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} wrState_t;

  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [WORD_W-1:0]      mem [DEPTH];
  logic [FIFO_AWIDTH-1:0] wrPtr, wrCommit, rdPtr, usedWords;
  wrState_t               wrState, wrStateNext;
  logic                   beatIn, room, wrEn, commit, rewind, dropFrame;

  logic                   pop, rdEn, loadOut;
  logic [1:0]             occAfter;
  logic                   vld_p0, vld_p1, skidVld;
  logic [WORD_W-1:0]      word_p0, word_p1, skidWord;
  logic [CNT_WIDTH-1:0]   frameCnt, dropCnt;

  assign siELP_Data_tready = ~piETH_CoreReset;
  assign beatIn            = siELP_Data_tvalid & ~piETH_CoreReset;
  assign usedWords         = wrPtr - rdPtr;
  // One slot stays empty so that used == 0 unambiguously means empty.
  assign room              = (usedWords != '1);

  always_ff @(posedge piETH_CoreClk) begin
    if (piETH_CoreReset) wrState <= W_IDLE;
    else                 wrState <= wrStateNext;
  end

  always_comb begin
    wrStateNext = wrState;
    case (wrState)
      W_IDLE, W_FRAME: begin
        if (beatIn) begin
          if (siELP_Data_tlast) wrStateNext = W_IDLE;
          else if (room)        wrStateNext = W_FRAME;
          else                  wrStateNext = W_DROP;
        end
      end
      W_DROP: begin
        if (beatIn && siELP_Data_tlast) wrStateNext = W_IDLE;
      end
      default: wrStateNext = W_IDLE;
    endcase
  end

  always_comb begin
    wrEn      = 1'b0;
    commit    = 1'b0;
    rewind    = 1'b0;
    dropFrame = 1'b0;
    if (beatIn && (wrState != W_DROP)) begin
      if (room) begin
        wrEn   = 1'b1;
        commit = siELP_Data_tlast;
      end else begin
        rewind    = 1'b1;
        dropFrame = 1'b1;
      end
    end
  end

  always_ff @(posedge piETH_CoreClk) begin
    if (piETH_CoreReset) begin
      wrPtr    <= '0;
      wrCommit <= '0;
      dropCnt  <= '0;
    end else begin
      if (rewind)    wrPtr <= wrCommit;
      else if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (commit)    wrCommit <= wrPtr + 1'b1;
      if (dropFrame) dropCnt <= satInc(dropCnt);
    end
  end

  always_ff @(posedge piETH_CoreClk) begin
    if (wrEn) mem[wrPtr] <= {siELP_Data_tlast, siELP_Data_tkeep, siELP_Data_tdata};
  end

  // p0: RAM read register. A read is issued only if, after this edge, out+skid
  // would hold at most one word, so the word landing in p0 always finds a slot.
  assign pop      = vld_p1 & soLY2_Data_tready;
  assign loadOut  = ~vld_p1 | pop;
  assign occAfter = 2'(vld_p1) + 2'(skidVld) + 2'(vld_p0) - 2'(pop);
  assign rdEn     = (rdPtr != wrCommit) && (occAfter <= 2'd1);

  always_ff @(posedge piETH_CoreClk) begin
    if (piETH_CoreReset) begin
      rdPtr  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= rdEn;
      if (rdEn) rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge piETH_CoreClk) begin
    if (rdEn) word_p0 <= mem[rdPtr];
  end

  // p1: output register, refilled from the skid word first, then from p0.
  always_ff @(posedge piETH_CoreClk) begin
    if (piETH_CoreReset) begin
      vld_p1  <= 1'b0;
      skidVld <= 1'b0;
      word_p1 <= '0;
    end else if (loadOut) begin
      if (skidVld) begin
        vld_p1  <= 1'b1;
        word_p1 <= skidWord;
        skidVld <= vld_p0;
      end else begin
        vld_p1  <= vld_p0;
        if (vld_p0) word_p1 <= word_p0;
      end
    end else if (vld_p0) begin
      skidVld <= 1'b1;
    end
  end

  always_ff @(posedge piETH_CoreClk) begin
    if (vld_p0 && (loadOut ? skidVld : 1'b1)) skidWord <= word_p0;
  end

  always_ff @(posedge piETH_CoreClk) begin
    if (piETH_CoreReset)       frameCnt <= '0;
    else if (pop && word_p1[72]) frameCnt <= frameCnt + 1'b1;
  end

  assign soLY2_Data_tvalid = vld_p1;
  assign soLY2_Data_tdata  = word_p1[63:0];
  assign soLY2_Data_tkeep  = word_p1[71:64];
  assign soLY2_Data_tlast  = word_p1[72];
  assign poMMIO_FrameCnt   = frameCnt;
  assign poMMIO_DropCnt    = dropCnt;

endmodule

// File: tb/tb_tengig_eth_tx_frame_fifo.sv
// Bench for tengig_eth_tx_frame_fifo: a large instance (1023 words) and a small one
// (63 words) share the input stream; each scenario checks one of them against a frame-level model.
module tb_tengig_eth_tx_frame_fifo;
  localparam int CAP_S = 63;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] inData = '0;
  logic [7:0]  inKeep = '0;
  logic        inLast = 1'b0;
  logic        inValid = 1'b0;
  logic        inReadyA, inReadyS;
  logic        readyA = 1'b1, readyS = 1'b1;
  logic [63:0] dataA, dataS;
  logic [7:0]  keepA, keepS;
  logic        lastA, lastS, validA, validS;
  logic [15:0] frameCntA, dropCntA, frameCntS, dropCntS;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int firstVldA = -1;
  int bubbleA = 0;
  int unstableA = 0;
  bit inFrameA = 1'b0;
  bit stallA = 1'b0;
  logic [72:0] heldA = '0;

  logic [72:0] obsA[$], expA[$], obsS[$], expS[$], lastFrame[$];

  tengig_eth_tx_frame_fifo #(.FIFO_AWIDTH(10), .CNT_WIDTH(16)) dutA (
    .piETH_CoreClk(clk), .piETH_CoreReset(rst),
    .siELP_Data_tdata(inData), .siELP_Data_tkeep(inKeep), .siELP_Data_tlast(inLast),
    .siELP_Data_tvalid(inValid), .siELP_Data_tready(inReadyA),
    .soLY2_Data_tdata(dataA), .soLY2_Data_tkeep(keepA), .soLY2_Data_tlast(lastA),
    .soLY2_Data_tvalid(validA), .soLY2_Data_tready(readyA),
    .poMMIO_FrameCnt(frameCntA), .poMMIO_DropCnt(dropCntA)
  );

  tengig_eth_tx_frame_fifo #(.FIFO_AWIDTH(6), .CNT_WIDTH(16)) dutS (
    .piETH_CoreClk(clk), .piETH_CoreReset(rst),
    .siELP_Data_tdata(inData), .siELP_Data_tkeep(inKeep), .siELP_Data_tlast(inLast),
    .siELP_Data_tvalid(inValid), .siELP_Data_tready(inReadyS),
    .soLY2_Data_tdata(dataS), .soLY2_Data_tkeep(keepS), .soLY2_Data_tlast(lastS),
    .soLY2_Data_tvalid(validS), .soLY2_Data_tready(readyS),
    .poMMIO_FrameCnt(frameCntS), .poMMIO_DropCnt(dropCntS)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output recorders: log handshakes and protocol events, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      inFrameA = 1'b0;
      stallA   = 1'b0;
    end else begin
      if (inFrameA && !validA) bubbleA++;
      if (stallA && (!validA || {lastA, keepA, dataA} !== heldA)) unstableA++;
      if (validA && firstVldA < 0) firstVldA = cyc;
      if (validA && readyA) begin
        obsA.push_back({lastA, keepA, dataA});
        inFrameA = !lastA;
      end
      stallA = validA && !readyA;
      heldA  = {lastA, keepA, dataA};
    end
  end

  always @(negedge clk) begin
    if (!rst && validS && readyS) obsS.push_back({lastS, keepS, dataS});
  end

  task automatic send_frame(input int len, input logic [7:0] lastKeep);
    lastFrame.delete();
    for (int i = 0; i < len; i++) begin
      logic [72:0] w;
      w[63:0]  = {$urandom, $urandom};
      w[71:64] = (i == len - 1) ? lastKeep : 8'hFF;
      w[72]    = (i == len - 1);
      inData = w[63:0]; inKeep = w[71:64]; inLast = w[72]; inValid = 1'b1;
      lastFrame.push_back(w);
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inValid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    obsA.delete(); expA.delete(); obsS.delete(); expS.delete();
    bubbleA = 0; unstableA = 0; firstVldA = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inData = {$urandom, $urandom}; inKeep = 8'hFF; inLast = 1'b1; inValid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (inReadyA !== 1'b0) begin failures++; $display("FAIL reset_tready: got %0b expected 0", inReadyA); end
    checks++; if (inReadyS !== 1'b0) begin failures++; $display("FAIL reset_tready_small: got %0b expected 0", inReadyS); end
    checks++; if (validA !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %0b expected 0", validA); end
    checks++; if (validS !== 1'b0) begin failures++; $display("FAIL reset_tvalid_small: got %0b expected 0", validS); end
    checks++; if ({lastA, keepA, dataA} !== 73'd0) begin failures++; $display("FAIL reset_tdata: got %h expected 0", {lastA, keepA, dataA}); end
    checks++; if (frameCntA !== 16'd0) begin failures++; $display("FAIL reset_framecnt: got %0d expected 0", frameCntA); end
    checks++; if (dropCntA !== 16'd0) begin failures++; $display("FAIL reset_dropcnt: got %0d expected 0", dropCntA); end
    inValid = 1'b0;
    rst = 1'b0;
    obsA.delete(); obsS.delete();
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (inReadyA !== 1'b1) begin failures++; $display("FAIL post_reset_tready: got %0b expected 1", inReadyA); end
    checks++; if (obsA.size() != 0) begin failures++; $display("FAIL reset_beat_ignored: got %0d beats expected 0", obsA.size()); end
  endtask

  task automatic test_single_frame();
    int tlastCyc;
    do_reset();
    readyA = 1'b1;
    send_frame(8, 8'h0F);
    tlastCyc = cyc;
    foreach (lastFrame[i]) expA.push_back(lastFrame[i]);
    for (int k = 0; k < 200 && obsA.size() < expA.size(); k++) begin @(posedge clk); #1; end
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (firstVldA - tlastCyc != 2) begin failures++; $display("FAIL single_latency: got %0d cycles expected 2", firstVldA - tlastCyc); end
    checks++; if (obsA.size() != expA.size()) begin failures++; $display("FAIL single_count: got %0d beats expected %0d", obsA.size(), expA.size()); end
    for (int i = 0; i < expA.size() && i < obsA.size(); i++) begin
      checks++; if (obsA[i] !== expA[i]) begin failures++; $display("FAIL single_beat[%0d]: got %h expected %h", i, obsA[i], expA[i]); end
    end
    checks++; if (frameCntA !== 16'd1) begin failures++; $display("FAIL single_framecnt: got %0d expected 1", frameCntA); end
    checks++; if (dropCntA !== 16'd0) begin failures++; $display("FAIL single_dropcnt: got %0d expected 0", dropCntA); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    readyA = 1'b1;
    for (int f = 0; f < 100; f++) begin
      send_frame($urandom_range(1, 190), 8'($urandom));
      foreach (lastFrame[i]) expA.push_back(lastFrame[i]);
    end
    for (int k = 0; k < 3000 && obsA.size() < expA.size(); k++) begin @(posedge clk); #1; end
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (obsA.size() != expA.size()) begin failures++; $display("FAIL b2b_count: got %0d beats expected %0d", obsA.size(), expA.size()); end
    for (int i = 0; i < expA.size() && i < obsA.size(); i++) begin
      checks++; if (obsA[i] !== expA[i]) begin failures++; $display("FAIL b2b_beat[%0d]: got %h expected %h", i, obsA[i], expA[i]); end
    end
    checks++; if (bubbleA != 0) begin failures++; $display("FAIL b2b_bubbles: got %0d expected 0", bubbleA); end
    checks++; if (frameCntA !== 16'd100) begin failures++; $display("FAIL b2b_framecnt: got %0d expected 100", frameCntA); end
    checks++; if (dropCntA !== 16'd0) begin failures++; $display("FAIL b2b_dropcnt: got %0d expected 0", dropCntA); end
  endtask

  task automatic test_random_backpressure();
    bit done = 1'b0;
    do_reset();
    fork
      begin
        for (int f = 0; f < 20; f++) begin
          send_frame($urandom_range(1, 40), 8'($urandom));
          foreach (lastFrame[i]) expA.push_back(lastFrame[i]);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        for (int k = 0; k < 6000 && (!done || obsA.size() < expA.size()); k++) begin
          readyA = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        readyA = 1'b1;
      end
    join
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (obsA.size() != expA.size()) begin failures++; $display("FAIL bp_count: got %0d beats expected %0d", obsA.size(), expA.size()); end
    for (int i = 0; i < expA.size() && i < obsA.size(); i++) begin
      checks++; if (obsA[i] !== expA[i]) begin failures++; $display("FAIL bp_beat[%0d]: got %h expected %h", i, obsA[i], expA[i]); end
    end
    checks++; if (unstableA != 0) begin failures++; $display("FAIL bp_stall_stability: got %0d violations expected 0", unstableA); end
    checks++; if (bubbleA != 0) begin failures++; $display("FAIL bp_bubbles: got %0d expected 0", bubbleA); end
    checks++; if (frameCntA !== 16'd20) begin failures++; $display("FAIL bp_framecnt: got %0d expected 20", frameCntA); end
  endtask

  task automatic test_overflow();
    int held = 0;
    int expDrops = 0;
    int lens[2] = '{40, 30};
    do_reset();
    readyS = 1'b0;
    foreach (lens[f]) begin
      send_frame(lens[f], 8'($urandom));
      if (lens[f] <= CAP_S - held) begin
        foreach (lastFrame[i]) expS.push_back(lastFrame[i]);
        held += lens[f];
      end else begin
        expDrops++;
      end
    end
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (dropCntS !== 16'(expDrops)) begin failures++; $display("FAIL ovf_dropcnt: got %0d expected %0d", dropCntS, expDrops); end
    checks++; if (obsS.size() != 0) begin failures++; $display("FAIL ovf_stalled_output: got %0d beats expected 0", obsS.size()); end
    readyS = 1'b1;
    for (int k = 0; k < 300 && obsS.size() < expS.size(); k++) begin @(posedge clk); #1; end
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (obsS.size() != expS.size()) begin failures++; $display("FAIL ovf_count: got %0d beats expected %0d", obsS.size(), expS.size()); end
    for (int i = 0; i < expS.size() && i < obsS.size(); i++) begin
      checks++; if (obsS[i] !== expS[i]) begin failures++; $display("FAIL ovf_beat[%0d]: got %h expected %h", i, obsS[i], expS[i]); end
    end
    checks++; if (frameCntS !== 16'd1) begin failures++; $display("FAIL ovf_framecnt: got %0d expected 1", frameCntS); end
  endtask

  task automatic test_oversize();
    int expDrops = 0;
    int lens[2] = '{70, 4};
    do_reset();
    readyS = 1'b1;
    foreach (lens[f]) begin
      send_frame(lens[f], 8'($urandom));
      if (lens[f] <= CAP_S) foreach (lastFrame[i]) expS.push_back(lastFrame[i]);
      else expDrops++;
    end
    for (int k = 0; k < 300 && obsS.size() < expS.size(); k++) begin @(posedge clk); #1; end
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (dropCntS !== 16'(expDrops)) begin failures++; $display("FAIL oversize_dropcnt: got %0d expected %0d", dropCntS, expDrops); end
    checks++; if (obsS.size() != expS.size()) begin failures++; $display("FAIL oversize_count: got %0d beats expected %0d", obsS.size(), expS.size()); end
    for (int i = 0; i < expS.size() && i < obsS.size(); i++) begin
      checks++; if (obsS[i] !== expS[i]) begin failures++; $display("FAIL oversize_beat[%0d]: got %h expected %h", i, obsS[i], expS[i]); end
    end
    checks++; if (frameCntS !== 16'd1) begin failures++; $display("FAIL oversize_framecnt: got %0d expected 1", frameCntS); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    readyA = 1'b1;
    send_frame(30, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      inData = {$urandom, $urandom}; inKeep = 8'hFF; inLast = 1'b0; inValid = 1'b1;
      if (i == 4) begin
        checks++; if (validA !== 1'b1) begin failures++; $display("FAIL midrst_pre_tvalid: got %0b expected 1", validA); end
        checks++; if (obsA.size() < 1 || obsA.size() > 29) begin failures++; $display("FAIL midrst_pre_partial: got %0d beats expected 1..29", obsA.size()); end
        rst = 1'b1;
      end
      @(posedge clk); #1;
    end
    checks++; if (validA !== 1'b0) begin failures++; $display("FAIL midrst_tvalid: got %0b expected 0", validA); end
    checks++; if ({lastA, keepA, dataA} !== 73'd0) begin failures++; $display("FAIL midrst_tdata: got %h expected 0", {lastA, keepA, dataA}); end
    checks++; if (inReadyA !== 1'b0) begin failures++; $display("FAIL midrst_tready: got %0b expected 0", inReadyA); end
    checks++; if (frameCntA !== 16'd0) begin failures++; $display("FAIL midrst_framecnt: got %0d expected 0", frameCntA); end
    inValid = 1'b0;
    rst = 1'b0;
    obsA.delete(); expA.delete();
    repeat (5) begin @(posedge clk); #1; end
    send_frame(3, 8'h03);
    foreach (lastFrame[i]) expA.push_back(lastFrame[i]);
    for (int k = 0; k < 200 && obsA.size() < expA.size(); k++) begin @(posedge clk); #1; end
    repeat (40) begin @(posedge clk); #1; end
    checks++; if (obsA.size() != expA.size()) begin failures++; $display("FAIL midrst_count: got %0d beats expected %0d", obsA.size(), expA.size()); end
    for (int i = 0; i < expA.size() && i < obsA.size(); i++) begin
      checks++; if (obsA[i] !== expA[i]) begin failures++; $display("FAIL midrst_beat[%0d]: got %h expected %h", i, obsA[i], expA[i]); end
    end
    checks++; if (frameCntA !== 16'd1) begin failures++; $display("FAIL midrst_framecnt_after: got %0d expected 1", frameCntA); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_random_backpressure();
    test_overflow();
    test_oversize();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
